// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing generator and monochrome framebuffer reader.
// Issues word reads to a 1-cycle synchronous RAM, unpacks each byte MSB first,
// and drives registered sync/de/colour with a fixed 3-cycle latency from the
// counter position.
// Optional feature macro: VGA_SCANOUT_PIXDBL_EN (320x240 content, 2x2 pixel doubling).
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 17,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [7:0]        rd_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              frame_start,
  output logic              vblank
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

`ifdef VGA_SCANOUT_PIXDBL_EN
  // each word covers 16 output pixels; rows of words advance every other line
  localparam int WSH = 4;
`else
  localparam int WSH = 3;
`endif

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_ACTIVE >> WSH);

  typedef struct packed {
    logic vis;  // visible area
    logic hs;   // inside hsync pulse (active high internally)
    logic vs;   // inside vsync pulse
    logic fs;   // position (0,0)
    logic vb;   // vertical blanking
    logic ld;   // word boundary: load shift register
    logic en;   // scan_en sampled with this position
    logic ph;   // shift enable for this pixel
  } ctl_t;

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [ADDR_W-1:0] line_base;
  logic [7:0]        shreg;
  ctl_t              c0, c1, c2;
  logic              h_last, v_last, row_step, pix;
  logic [11:0]       color;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

`ifdef VGA_SCANOUT_PIXDBL_EN
  assign row_step = v_cnt[0];
`else
  assign row_step = 1'b1;
`endif

  // decode the current counter position into the control bits that ride the pipeline
  always_comb begin
    c0     = '0;
    c0.vis = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    c0.hs  = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    c0.vs  = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
    c0.fs  = (h_cnt == '0) && (v_cnt == '0);
    c0.vb  = (v_cnt >= V_ACT_C);
    c0.ld  = c0.vis && (h_cnt[WSH-1:0] == '0);
    c0.en  = scan_en;
`ifdef VGA_SCANOUT_PIXDBL_EN
    c0.ph  = h_cnt[0];
`else
    c0.ph  = 1'b1;
`endif
  end

  // horizontal and vertical position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // incremental word addressing: line base steps one row of words per (pair of) visible lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base <= BASE_ADDR;
      read_addr <= BASE_ADDR;
    end else begin
      if (h_last) begin
        if (v_last)
          line_base <= BASE_ADDR;
        else if ((v_cnt < V_ACT_C) && row_step)
          line_base <= line_base + STRIDE;
      end
      if (c0.ld)
        read_addr <= line_base + ADDR_W'(h_cnt >> WSH);
    end
  end

  // delay control two cycles to line up with the RAM read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1 <= '0;
      c2 <= '0;
    end else begin
      c1 <= c0;
      c2 <= c1;
    end
  end

  // pixel 0 of a word comes straight from rd_data; the rest from the shift register
  assign pix   = c2.ld ? rd_data[7] : shreg[7];
  assign color = !c2.vis ? 12'h000 : ((c2.en && pix) ? FG_COLOR : BG_COLOR);

  // unpack shift register and registered output pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      if (c2.ld) begin
`ifdef VGA_SCANOUT_PIXDBL_EN
        shreg <= rd_data;
`else
        shreg <= rd_data << 1;
`endif
      end else if (c2.ph) begin
        shreg <= shreg << 1;
      end
      hsync       <= ~c2.hs;
      vsync       <= ~c2.vs;
      de          <= c2.vis;
      frame_start <= c2.fs;
      vblank      <= c2.vb;
      vga_r       <= color[11:8];
      vga_g       <= color[7:4];
      vga_b       <= color[3:0];
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: a full-size instance for line timing,
// addressing and unpack, and a shrunken-timing instance for frame-level
// behaviour (vsync, vblank, frame wrap, scan_en blanking).
module tb_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, scan_en, scan_en_s;
  logic [16:0] read_addr, read_addr_s;
  logic [7:0]  rd_data, rd_data_s;
  logic        hsync, vsync, de, frame_start, vblank;
  logic        hsync_s, vsync_s, de_s, frame_start_s, vblank_s;
  logic [3:0]  vga_r, vga_g, vga_b, vga_r_s, vga_g_s, vga_b_s;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int de_cnt, hs_cnt;

  localparam logic [7:0] PAT0 = 8'hA5;

  vga_scanout dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en),
    .read_addr(read_addr), .rd_data(rd_data),
    .hsync(hsync), .vsync(vsync), .de(de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .vblank(vblank)
  );

  // 16x4 visible, H_TOT 24, V_TOT 8: hsync h 18..20, vsync lines 5..6
  vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en_s),
    .read_addr(read_addr_s), .rd_data(rd_data_s),
    .hsync(hsync_s), .vsync(vsync_s), .de(de_s),
    .vga_r(vga_r_s), .vga_g(vga_g_s), .vga_b(vga_b_s),
    .frame_start(frame_start_s), .vblank(vblank_s)
  );

  function automatic logic [7:0] ram(input logic [16:0] a);
    return (a == 17'd0) ? PAT0 : a[7:0];
  endfunction

  // framebuffer model: one-cycle registered read
  always @(posedge clk) begin
    rd_data   <= ram(read_addr);
    rd_data_s <= ram(read_addr_s);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs then reflect counter position cyc-3
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    rst_n = 1'b0; scan_en = 1'b1; scan_en_s = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("pre_reset_de", 32'(de), 1);

    // mid-line reset
    rst_n = 1'b0;
    #1;
    chk("rst_read_addr", 32'(read_addr), 0);
    chk("rst_de", 32'(de), 0);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_vga", 32'({vga_r, vga_g, vga_b}), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_vblank", 32'(vblank), 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_de", 32'(de), 0);
    chk("rst_hold_addr", 32'(read_addr), 0);
    rst_n = 1'b1;
    cyc = 0;

    run_to(1);
    chk("addr_first", 32'(read_addr), 0);
    chk("fs_c1", 32'(frame_start), 0);
    run_to(2);
    chk("fs_c2", 32'(frame_start), 0);

    for (int k = 0; k < 8; k++) begin
      run_to(3 + k);
      chk("unpack_a5", 32'(vga_r), PAT0[7-k] ? 32'hF : 32'h0);
      if (k == 0) begin
        chk("fs_c3", 32'(frame_start), 1);
        chk("de_first", 32'(de), 1);
        chk("vga_g_first", 32'(vga_g), 32'hF);
      end
      if (k == 1) chk("fs_c4", 32'(frame_start), 0);
    end
    chk("addr_word1", 32'(read_addr), 1);

    run_to(18);
    chk("px15_word1", 32'(vga_r), 32'hF);

    run_to(20);
    chk("s_hsync_h17", 32'(hsync_s), 1);
    run_to(21);
    chk("s_hsync_h18", 32'(hsync_s), 0);

    run_to(24);
    scan_en_s = 1'b0;
    run_to(25);
    chk("s_addr_line1", 32'(read_addr_s), 2);
    run_to(33);
    chk("s_blank_px", 32'(vga_r_s), 0);
    chk("s_blank_de", 32'(de_s), 1);

    run_to(48);
    scan_en_s = 1'b1;
    run_to(55);
    chk("s_line2_px4", 32'(vga_r_s), 0);
    run_to(56);
    chk("s_line2_px5", 32'(vga_r_s), 32'hF);

    run_to(81);
    chk("s_addr_last", 32'(read_addr_s), 7);
    run_to(98);
    chk("s_vblank_v3", 32'(vblank_s), 0);
    run_to(99);
    chk("s_vblank_v4", 32'(vblank_s), 1);
    run_to(122);
    chk("s_vsync_v4", 32'(vsync_s), 1);
    run_to(123);
    chk("s_vsync_v5", 32'(vsync_s), 0);
    run_to(150);
    chk("s_addr_hold", 32'(read_addr_s), 7);
    run_to(170);
    chk("s_vsync_v6", 32'(vsync_s), 0);
    run_to(171);
    chk("s_vsync_v7", 32'(vsync_s), 1);
    run_to(193);
    chk("s_addr_wrap", 32'(read_addr_s), 0);
    run_to(194);
    chk("s_fs_before", 32'(frame_start_s), 0);
    run_to(195);
    chk("s_fs_frame2", 32'(frame_start_s), 1);

    run_to(633);
    chk("addr_word79", 32'(read_addr), 79);
    run_to(642);
    chk("de_px639", 32'(de), 1);
    run_to(643);
    chk("de_px640", 32'(de), 0);
    chk("vga_px640", 32'(vga_r), 0);
    run_to(658);
    chk("hsync_h655", 32'(hsync), 1);
    run_to(659);
    chk("hsync_h656", 32'(hsync), 0);
    run_to(754);
    chk("hsync_h751", 32'(hsync), 0);
    run_to(755);
    chk("hsync_h752", 32'(hsync), 1);
    run_to(801);
    chk("addr_line1", 32'(read_addr), 80);

    run_to(802);
    de_cnt = 0;
    hs_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      step();
      if (de) de_cnt++;
      if (!hsync) hs_cnt++;
    end
    chk("line1_de_count", 32'(de_cnt), 640);
    chk("line1_hsync_count", 32'(hs_cnt), 96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
